// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the burst-aware wishbone lane arbiter.
package wb_arb_pkg;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned BL_W      = 10;
  localparam int unsigned GNT_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StRel  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker: first requester after the last owner, with wrap.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         last_i,
  output logic [1:0]         idx_o,
  output logic               any_o
);

  logic [1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last_i + 2'(k);
      if (!any_o && req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_burst_arb.sv
// Burst-holding round-robin arbiter for four wishbone master lanes.
// Optional stall watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_burst_arb
  import wb_arb_pkg::*;
#(
  parameter int unsigned TOUT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*BL_W-1:0]   bl_i,
  input  logic                      ack_i,
  input  logic                      lack_i,
  input  logic [TOUT_W-1:0]         cfg_tout_i,
  output logic [1:0]                gnt_o,
  output logic                      gnt_vld_o,
  output logic                      busy_o,
  output logic                      tout_o,
  output logic [GNT_CNT_W-1:0]      gnt_cnt_o
);

  arb_state_e      state_q;
  logic [1:0]      last_q;
  logic [BL_W-1:0] beat_cnt_q;
  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [BL_W-1:0] bl_sel;
  logic            release_req;

  wb_rr_pick u_pick (
    .req_i  (req_i),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign bl_sel      = bl_i[32'(pick_idx) * BL_W +: BL_W];
  assign release_req = lack_i || (ack_i && (beat_cnt_q == BL_W'(1))) || !req_i[gnt_o];
  assign busy_o      = (state_q != StIdle);

`ifdef WB_ARB_WATCHDOG_EN
  logic [TOUT_W-1:0] tout_cnt_q;
  logic              tout_hit;

  // Fires on the stall cycle that brings the count up to the limit.
  assign tout_hit = (cfg_tout_i != '0) && !ack_i &&
                    ((tout_cnt_q + TOUT_W'(1)) == cfg_tout_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tout_cnt_q <= '0;
    end else if (state_q == StIdle) begin
      tout_cnt_q <= '0;
    end else if (state_q == StBusy) begin
      tout_cnt_q <= ack_i ? '0 : tout_cnt_q + TOUT_W'(1);
    end
  end
`else
  logic unused_cfg_tout;
  logic tout_hit;

  assign unused_cfg_tout = ^cfg_tout_i;
  assign tout_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      gnt_o      <= '0;
      gnt_vld_o  <= 1'b0;
      tout_o     <= 1'b0;
      gnt_cnt_o  <= '0;
      last_q     <= 2'd3;
      beat_cnt_q <= '0;
    end else begin
      tout_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            gnt_o      <= pick_idx;
            gnt_vld_o  <= 1'b1;
            last_q     <= pick_idx;
            beat_cnt_q <= (bl_sel == '0) ? BL_W'(1) : bl_sel;
            if (gnt_cnt_o != '1) begin
              gnt_cnt_o <= gnt_cnt_o + GNT_CNT_W'(1);
            end
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (ack_i) begin
            beat_cnt_q <= beat_cnt_q - BL_W'(1);
          end
          if (release_req) begin
            gnt_vld_o <= 1'b0;
            state_q   <= StRel;
          end else if (tout_hit) begin
            tout_o    <= 1'b1;
            gnt_vld_o <= 1'b0;
            state_q   <= StRel;
          end
        end
        // gnt_o is held through the gap so the mux path stays stable.
        StRel: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
